mul_share_arbiter: RTL and testbench
====================================

# mul_share_arbiter

Shares one combinational `booth16x16_top` multiplier between `NUM_REQ` requesters using round-robin arbitration and valid/ready handshakes. A single-entry registered response stage returns the 32-bit product, the flags and the requester ID one cycle after acceptance, with backpressure. It sits between the ALU issue ports (scalar ALU, address-gen, DSP helper) and the shared multiplier datapath.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester ID.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit set.
- `req_a`  in  16*NUM_REQ  operand A, requester i at bits [16i+15:16i].
- `req_b`  in  16*NUM_REQ  operand B, same packing as `req_a`.
- `req_signed`  in  NUM_REQ  per-requester signed mode (feeds `alu_signed`).
- `rsp_valid`  out  1  response register holds a result.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_id`  out  ID_W  index of the requester that owns the result.
- `rsp_prod`  out  32  registered PROD_RESULT.
- `rsp_neg`  out  1  registered neg_flag.
- `rsp_zero`  out  1  registered zero_flag.

## Operation
- Two states:
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
- `can_accept = !rsp_valid || rsp_ready`.
- Grant:
  - Round-robin starting at pointer `rr_ptr`.
  - The first `i` with `req_valid[i]` set, scanning `rr_ptr, rr_ptr+1, …` modulo NUM_REQ, is granted.
  - `req_ready[i] = grant[i] && can_accept`.
- Accept (`req_valid[g] && req_ready[g]`):
  - Granted operands and sign drive the multiplier mux.
  - Results load into `rsp_*`; `rsp_id` = g; next state is FULL.
  - `rr_ptr` ← (g+1) mod NUM_REQ.
- No accept while FULL and `rsp_ready`=1: next state is EMPTY.
- FULL and `rsp_ready`=0: all `rsp_*` are held stable and `req_ready` is all zero.
- Simultaneous consume and accept in the same cycle: the new result replaces the old. The state stays FULL with no bubble.
- No `req_valid` bits set: `rr_ptr` holds and the multiplier inputs are driven to 0.
- Arithmetic:
  - Identical to `booth16x16_top`: unsigned 16x16→32, or signed two's complement.
  - `rsp_neg` = product bit 31 in signed mode, 0 in unsigned mode.
  - `rsp_zero` = (product == 0).
- Handshake rules:
  - Requesters must hold `req_valid` and operands stable until accepted.
  - `req_ready` may depend combinationally on `req_valid`.
  - `rsp_valid` never depends on `rsp_ready` in the same cycle.
- Reset (`rst`=1 at a clock edge, including mid-hold):
  - `rsp_valid`=0, `rsp_id`=0, `rsp_prod`=0, `rsp_neg`=0, `rsp_zero`=0, `rr_ptr`=0.
  - Any held result is discarded.
  - `req_ready` is all zero while `rst`=1.

## Timing
- Request-to-response latency: 1 cycle. Accept at edge N makes `rsp_valid`=1 after edge N.
- Throughput: 1 result per cycle while `rsp_ready`=1.
- The multiplier path (mux + booth16x16_top) lies fully between the requester inputs and the `rsp_*` registers. This path is the single critical path.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.

## Configuration
- `MUL_ARB_STATS_EN` defined:
  - Adds output `op_count` [15:0]: accepted requests, saturating at 0xFFFF.
  - Adds output `stall_count` [15:0]: cycles with `rsp_valid`=1 and `rsp_ready`=0, saturating at 0xFFFF.
  - Both reset to 0.
- `MUL_ARB_STATS_EN` undefined: these ports and counters do not exist, and the remaining behaviour is identical.

## Structure
- Package `mul_arb_pkg` holds:
  - `OPW`=16 and `PRODW`=32.
  - The default `NUM_REQ`.
  - A state enum with `ST_EMPTY` and `ST_FULL`.
  - A `mul_rsp_t` struct containing prod, neg, zero and id.
- Sub-module `rr_arbiter`: parameterised round-robin grant logic taking `req` and `ptr` and producing a one-hot `grant` and an encoded `gidx`.
- `booth16x16_top` is instantiated once, unmodified.

## Test plan
- Single request: requester 0 sends A=0x7FFF, B=0x8000, signed=1. Next cycle: `rsp_valid`=1, `rsp_id`=0, `rsp_prod`=0xC0008000, `rsp_neg`=1, `rsp_zero`=0.
- Full contention: all 4 requesters valid continuously with `rsp_ready`=1. Grants run 0,1,2,3,0,… one per cycle, and `rsp_valid` stays high every cycle after the first.
- Backpressure: unsigned 0xFFFF×0xFFFF is held with `rsp_ready`=0 for 3 cycles. `rsp_prod` stays 0xFFFE0001 and `req_ready` stays 0. When `rsp_ready` returns to 1, the next pending request is accepted in the same cycle.
- Reset mid-hold: `rst` is pulsed while FULL with `rr_ptr`=2. Next cycle: `rsp_valid`=0 and `rr_ptr`=0. Then, with requesters 0 and 2 valid, requester 0 is granted first.
- Edge values:
  - Unsigned 0x0000×0x1234 → `rsp_prod`=0, `rsp_zero`=1, `rsp_neg`=0.
  - Signed 0x8000×0x8000 → `rsp_prod`=0x40000000, `rsp_neg`=0.
  - Signed 0xFFFF×0xFFFF → `rsp_prod`=0x00000001.
- Stats (`MUL_ARB_STATS_EN` defined):
  - 5 accepts and 3 stall cycles → `op_count`=5, `stall_count`=3.
  - Forcing `op_count` to 0xFFFF and then accepting one more request leaves it at 0xFFFF.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared types and constants for the shared-multiplier arbiter.
//   OPW / PRODW   operand and product widths of the booth16x16_top datapath
//   NUM_REQ_DEF   default requester count
//   state_e       response-register occupancy (ST_EMPTY / ST_FULL)
//   mul_rsp_t     contents of the registered response stage
package mul_arb_pkg;

  localparam int OPW         = 16;
  localparam int PRODW       = 32;
  localparam int NUM_REQ_DEF = 4;
  // Widest requester ID for the supported 2..8 requesters.
  localparam int MAX_ID_W    = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  typedef struct packed {
    logic [PRODW-1:0]    prod;
    logic                neg;
    logic                zero;
    logic [MAX_ID_W-1:0] id;
  } mul_rsp_t;

endpackage

// File: rtl/booth16x16_top.sv
// booth16x16_top: combinational 16x16 -> 32 radix-4 Booth multiplier.
//   alu_a, alu_b   16-bit operands
//   alu_signed     1 = two's complement operands, 0 = unsigned
//   PROD_RESULT    32-bit product
//   neg_flag       product bit 31 in signed mode, 0 in unsigned mode
//   zero_flag      product is zero
module booth16x16_top (
  input  logic [15:0] alu_a,
  input  logic [15:0] alu_b,
  input  logic        alu_signed,
  output logic [31:0] PROD_RESULT,
  output logic        neg_flag,
  output logic        zero_flag
);

  logic [31:0] a_ext;
  logic [18:0] b_ext;
  logic [31:0] pp;
  logic [31:0] acc;
  logic [2:0]  win;

  // Both operands are extended by one extra bit (sign or zero) so the unsigned
  // case is handled as a signed 17x17 multiply; the low 32 bits are exact.
  // b_ext carries a second extension bit plus the implicit 0 below the LSB so
  // nine overlapping 3-bit Booth windows cover it.
  always_comb begin
    a_ext = {{16{alu_signed & alu_a[15]}}, alu_a};
    b_ext = {{2{alu_signed & alu_b[15]}}, alu_b, 1'b0};
    acc   = '0;
    pp    = '0;
    win   = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      win = b_ext[2*i +: 3];
      case (win)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext << 1;
        3'b100:         pp = -(a_ext << 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2*i));
    end
  end

  assign PROD_RESULT = acc;
  assign neg_flag    = alu_signed & acc[31];
  assign zero_flag   = (acc == '0);

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   req    request vector
//   ptr    highest-priority index; scanning goes ptr, ptr+1, ... modulo N
//   grant  one-hot grant (all zero when no request)
//   gidx   encoded index of the granted requester (0 when none)
//   any    at least one request is present
module rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] gidx,
  output logic         any
);

  logic found;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned idx;
      idx = (32'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = W'(idx);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: shares one booth16x16_top between NUM_REQ requesters with
// round-robin arbitration and a single-entry registered response stage.
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    per-requester handshake (at most one ready bit)
//   req_a, req_b           packed 16-bit operands, requester i at [16i+15:16i]
//   req_signed             per-requester signed mode
//   rsp_valid/rsp_ready    response handshake
//   rsp_id, rsp_prod,
//   rsp_neg, rsp_zero      registered result and its owner
// Optional build macro MUL_ARB_STATS_EN adds op_count / stall_count outputs
// (saturating 16-bit counters of accepts and backpressure cycles).
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [OPW*NUM_REQ-1:0] req_a,
  input  logic [OPW*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]     req_signed,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [PRODW-1:0]       rsp_prod,
  output logic                   rsp_neg,
  output logic                   rsp_zero
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [15:0]            op_count,
  output logic [15:0]            stall_count
`endif
);

  state_e            state_q, state_d;
  mul_rsp_t          rsp_q, rsp_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gidx;
  logic               any_req;
  logic               can_accept;
  logic               accept;

  logic [OPW-1:0]     mul_a, mul_b;
  logic               mul_signed;
  logic [PRODW-1:0]   mul_prod;
  logic               mul_neg, mul_zero;

  rr_arbiter #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .gidx  (gidx),
    .any   (any_req)
  );

  assign can_accept = (state_q == ST_EMPTY) || rsp_ready;
  assign req_ready  = (rst || !can_accept) ? '0 : grant;
  assign accept     = |(req_valid & req_ready);

  // Idle inputs are forced to zero so the multiplier does not toggle.
  always_comb begin
    mul_a      = '0;
    mul_b      = '0;
    mul_signed = 1'b0;
    if (any_req) begin
      mul_a      = req_a[gidx*OPW +: OPW];
      mul_b      = req_b[gidx*OPW +: OPW];
      mul_signed = req_signed[gidx];
    end
  end

  booth16x16_top u_mul (
    .alu_a       (mul_a),
    .alu_b       (mul_b),
    .alu_signed  (mul_signed),
    .PROD_RESULT (mul_prod),
    .neg_flag    (mul_neg),
    .zero_flag   (mul_zero)
  );

  // An accept always reloads the response register, which also covers the
  // consume-and-accept cycle without a bubble.
  always_comb begin
    state_d  = state_q;
    rsp_d    = rsp_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rsp_d.prod = mul_prod;
      rsp_d.neg  = mul_neg;
      rsp_d.zero = mul_zero;
      rsp_d.id   = MAX_ID_W'(gidx);
      state_d    = ST_FULL;
      rr_ptr_d   = (gidx == ID_W'(NUM_REQ-1)) ? '0 : gidx + ID_W'(1);
    end else if (state_q == ST_FULL && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      rsp_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rsp_q    <= rsp_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_id    = rsp_q.id[ID_W-1:0];
  assign rsp_prod  = rsp_q.prod;
  assign rsp_neg   = rsp_q.neg;
  assign rsp_zero  = rsp_q.zero;

  // The packed ID field is sized for the largest requester count.
  logic unused_id_bits;
  assign unused_id_bits = ^rsp_q.id;

`ifdef MUL_ARB_STATS_EN
  logic [15:0] op_count_q, op_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    op_count_d    = op_count_q;
    stall_count_d = stall_count_q;
    if (accept && op_count_q != '1) begin
      op_count_d = op_count_q + 16'd1;
    end
    if (state_q == ST_FULL && !rsp_ready && stall_count_q != '1) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      op_count_q    <= op_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign op_count    = op_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: scoreboard bench for mul_share_arbiter (NUM_REQ=4).
// Build with MUL_ARB_STATS_EN defined to also cover the statistics counters.
module tb_mul_share_arbiter;

  localparam int NR = 4;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [16*NR-1:0]  req_a;
  logic [16*NR-1:0]  req_b;
  logic [NR-1:0]     req_signed;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [31:0]       rsp_prod;
  logic              rsp_neg;
  logic              rsp_zero;
`ifdef MUL_ARB_STATS_EN
  logic [15:0]       op_count;
  logic [15:0]       stall_count;
`endif

  mul_share_arbiter #(
    .NUM_REQ (NR),
    .ID_W    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_prod   (rsp_prod),
    .rsp_neg    (rsp_neg),
    .rsp_zero   (rsp_zero)
`ifdef MUL_ARB_STATS_EN
    ,
    .op_count    (op_count),
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] prod;
    logic        neg;
    logic        zero;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          ptr      = 0;
  logic        pend [NR];
  logic [15:0] opa  [NR];
  logic [15:0] opb  [NR];
  logic        sgn  [NR];
  logic        refill = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic exp_t model(input int g);
    exp_t m;
    logic signed [31:0] sa, sbv;
    logic [31:0] p;
    if (sgn[g]) begin
      sa  = {{16{opa[g][15]}}, opa[g]};
      sbv = {{16{opb[g][15]}}, opb[g]};
      p   = sa * sbv;
    end else begin
      p = {16'h0, opa[g]} * {16'h0, opb[g]};
    end
    m.id   = g[1:0];
    m.prod = p;
    m.neg  = sgn[g] & p[31];
    m.zero = (p == 32'h0);
    return m;
  endfunction

  task automatic post(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
    pend[i] = 1'b1;
    opa[i]  = a;
    opb[i]  = b;
    sgn[i]  = s;
  endtask

  task automatic post_random(input int i);
    post(i, 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  // One clock cycle: drive, check req_ready against the model at the falling
  // edge, then check the response register just after the rising edge.
  task automatic step(input logic rdy, input logic do_rst);
    logic [NR-1:0] exp_rdy;
    int            g;
    logic          full;
    logic          acc;
    rsp_ready = rdy;
    rst       = do_rst;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = pend[i];
      req_a[16*i +: 16]    = opa[i];
      req_b[16*i +: 16]    = opb[i];
      req_signed[i]        = sgn[i];
    end
    @(negedge clk);
    full = (sb.size() != 0);
    g    = -1;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (ptr + k) % NR;
      if (g < 0 && pend[idx]) g = idx;
    end
    exp_rdy = '0;
    if (!do_rst && g >= 0 && (!full || rdy)) exp_rdy[g] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    acc = (exp_rdy != '0);
    @(posedge clk);
    #1;
    if (do_rst) begin
      sb.delete();
      ptr = 0;
    end else begin
      if (full && rdy) void'(sb.pop_front());
      if (acc) begin
        sb.push_back(model(g));
        ptr     = (g + 1) % NR;
        pend[g] = 1'b0;
        if (refill) post_random(g);
      end
    end
    if (sb.size() != 0) begin
      check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("rsp_id",    32'(rsp_id),    32'(sb[0].id));
      check_eq("rsp_prod",  rsp_prod,       sb[0].prod);
      check_eq("rsp_neg",   32'(rsp_neg),   32'(sb[0].neg));
      check_eq("rsp_zero",  32'(rsp_zero),  32'(sb[0].zero));
    end else begin
      check_eq("rsp_valid", 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0;
      opa[i]  = '0;
      opb[i]  = '0;
      sgn[i]  = 1'b0;
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  initial begin
    rst        = 1'b1;
    rsp_ready  = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_signed = '0;
    clear_reqs();
    @(posedge clk);
    #1;

    // Reset values
    do_reset();
    check_eq("reset_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset_id",    32'(rsp_id),    32'd0);
    check_eq("reset_prod",  rsp_prod,       32'd0);
    check_eq("reset_neg",   32'(rsp_neg),   32'd0);
    check_eq("reset_zero",  32'(rsp_zero),  32'd0);

    // Single signed request from requester 0
    post(0, 16'h7FFF, 16'h8000, 1'b1);
    step(1'b1, 1'b0);
    check_eq("single_valid", 32'(rsp_valid), 32'd1);
    check_eq("single_id",    32'(rsp_id),    32'd0);
    check_eq("single_prod",  rsp_prod,       32'hC0008000);
    check_eq("single_neg",   32'(rsp_neg),   32'd1);
    check_eq("single_zero",  32'(rsp_zero),  32'd0);
    step(1'b1, 1'b0);

    // Full contention from a fresh pointer: grants 0,1,2,3,0,...
    do_reset();
    refill = 1'b1;
    for (int i = 0; i < NR; i++) post_random(i);
    for (int c = 0; c < 12; c++) begin
      step(1'b1, 1'b0);
      check_eq("rr_order", 32'(rsp_id), 32'(c % NR));
    end
    refill = 1'b0;
    clear_reqs();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Backpressure: unsigned 0xFFFF*0xFFFF held for three cycles
    do_reset();
    post(0, 16'hFFFF, 16'hFFFF, 1'b0);
    step(1'b1, 1'b0);
    post(1, 16'h0003, 16'h0005, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0);
      check_eq("bp_prod",  rsp_prod,         32'hFFFE0001);
      check_eq("bp_ready", 32'(req_ready),   32'd0);
    end
    step(1'b1, 1'b0);
    check_eq("bp_next_id",   32'(rsp_id), 32'd1);
    check_eq("bp_next_prod", rsp_prod,    32'd15);
    step(1'b1, 1'b0);

    // Reset while FULL with rr_ptr at 2
    do_reset();
    post(1, 16'h0002, 16'h0002, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    post(0, 16'h0011, 16'h0003, 1'b0);
    post(2, 16'h0022, 16'h0003, 1'b0);
    step(1'b0, 1'b1);
    check_eq("rst_hold_valid", 32'(rsp_valid), 32'd0);
    step(1'b1, 1'b0);
    check_eq("rst_first_id", 32'(rsp_id), 32'd0);
    step(1'b1, 1'b0);
    check_eq("rst_second_id", 32'(rsp_id), 32'd2);
    step(1'b1, 1'b0);

    // Edge operand values
    post(3, 16'h0000, 16'h1234, 1'b0);
    step(1'b1, 1'b0);
    check_eq("zero_prod", rsp_prod,       32'd0);
    check_eq("zero_flag", 32'(rsp_zero),  32'd1);
    check_eq("zero_neg",  32'(rsp_neg),   32'd0);
    post(1, 16'h8000, 16'h8000, 1'b1);
    step(1'b1, 1'b0);
    check_eq("minmin_prod", rsp_prod,     32'h40000000);
    check_eq("minmin_neg",  32'(rsp_neg), 32'd0);
    post(2, 16'hFFFF, 16'hFFFF, 1'b1);
    step(1'b1, 1'b0);
    check_eq("m1m1_prod", rsp_prod, 32'h00000001);
    step(1'b1, 1'b0);

    // Random traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) post_random(i);
      end
      step(1'($urandom_range(0, 3) != 0), 1'b0);
    end
    clear_reqs();
    step(1'b1, 1'b0);

`ifdef MUL_ARB_STATS_EN
    // Five accepts followed by three stall cycles
    do_reset();
    for (int c = 0; c < 5; c++) begin
      post(c % NR, 16'(c + 1), 16'h0007, 1'b0);
      step(1'b1, 1'b0);
    end
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0);
    check_eq("op_count",    32'(op_count),    32'd5);
    check_eq("stall_count", 32'(stall_count), 32'd3);
    step(1'b1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
